// File: rtl/v2f_divmod_seq.sv
// v2f_divmod_seq: multi-cycle restoring divider producing quotient and
// remainder together, one quotient bit per clock.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid, in_ready  operand handshake (A dividend, B divisor)
//   out_valid, out_ready result handshake (Q quotient, R remainder)
//   dbz                 divisor was zero (only with V2F_DIVMOD_DBZ_EN)
//
// The operation is signed only when A_SIGNED and B_SIGNED are both set.
// The optional dbz port is compiled in by defining V2F_DIVMOD_DBZ_EN.
// Latency from accept to out_valid is WIDTH+1 clocks.
module v2f_divmod_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned A_SIGNED = 0,
    parameter int unsigned B_SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R
`ifdef V2F_DIVMOD_DBZ_EN
    ,
    output logic             dbz
`endif
);

    localparam int unsigned CW        = $clog2(WIDTH);
    localparam bit          SIGNED_OP = (A_SIGNED != 0) && (B_SIGNED != 0);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem;      // partial remainder, always < divisor
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] a_orig;   // raw dividend, returned as R on divide by zero
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             b_zero;

    logic             a_sign;
    logic             b_sign;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   b_ext;
    logic             step_ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             in_ready_d;
    logic             out_valid_d;

    // Operand magnitudes; negation wraps so the most negative value maps to itself
    assign a_sign = SIGNED_OP && A[WIDTH-1];
    assign b_sign = SIGNED_OP && B[WIDTH-1];
    assign a_abs  = a_sign ? WIDTH'(~A + 1'b1) : A;
    assign b_abs  = b_sign ? WIDTH'(~B + 1'b1) : B;

    // One restoring step on a WIDTH+1 bit remainder; the result always fits in WIDTH bits
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign b_ext     = {1'b0, b_mag};
    assign step_ge   = (rem_shift >= b_ext);
    assign rem_step  = step_ge ? WIDTH'(rem_shift - b_ext) : rem_shift[WIDTH-1:0];

    // Sign fix-up; a zero divisor overrides with all-ones quotient and raw dividend
    assign q_fix = b_zero ? '1     : (q_neg ? WIDTH'(~quo + 1'b1) : quo);
    assign r_fix = b_zero ? a_orig : (r_neg ? WIDTH'(~rem + 1'b1) : rem);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)      state_next = RUN;
            RUN:  if (cnt == '0)     state_next = FIX;
            FIX:                     state_next = DONE;
            DONE: if (out_ready)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they register in step with it
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_next)
            IDLE:    in_ready_d  = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Datapath: latch on accept, iterate in RUN, register results in FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo    <= '0;
            rem    <= '0;
            b_mag  <= '0;
            a_orig <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
            Q      <= '0;
            R      <= '0;
`ifdef V2F_DIVMOD_DBZ_EN
            dbz    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo    <= a_abs;
                        b_mag  <= b_abs;
                        a_orig <= A;
                        q_neg  <= a_sign ^ b_sign;
                        r_neg  <= a_sign;
                        b_zero <= (B == '0);
                        rem    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    quo <= {quo[WIDTH-2:0], step_ge};
                    rem <= rem_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    Q   <= q_fix;
                    R   <= r_fix;
`ifdef V2F_DIVMOD_DBZ_EN
                    dbz <= b_zero;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_v2f_divmod_seq.sv
// Directed testbench for v2f_divmod_seq at WIDTH=8. An unsigned and a signed
// instance share all inputs and run every operation in lockstep.
module tb_v2f_divmod_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] A;
    logic [7:0] B;

    logic       u_in_ready, u_out_valid;
    logic [7:0] u_q, u_r;
    logic       s_in_ready, s_out_valid;
    logic [7:0] s_q, s_r;
`ifdef V2F_DIVMOD_DBZ_EN
    logic       u_dbz, s_dbz;
`endif

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    v2f_divmod_seq #(.WIDTH(8), .A_SIGNED(0), .B_SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .A(A), .B(B), .out_valid(u_out_valid), .out_ready(out_ready),
        .Q(u_q), .R(u_r)
`ifdef V2F_DIVMOD_DBZ_EN
        , .dbz(u_dbz)
`endif
    );

    v2f_divmod_seq #(.WIDTH(8), .A_SIGNED(1), .B_SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(A), .B(B), .out_valid(s_out_valid), .out_ready(out_ready),
        .Q(s_q), .R(s_r)
`ifdef V2F_DIVMOD_DBZ_EN
        , .dbz(s_dbz)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one operand pair, then wait (bounded) for out_valid; lat = edges after accept
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int n);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        chk1("in_ready_before_accept", u_in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!u_out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk8("latency", 8'(n), 8'd9);
        chk1("signed_out_valid", s_out_valid, 1'b1);
    endtask

    // With out_ready high the result is taken on the next edge
    task automatic take_result();
        @(posedge clk);
        #1;
        chk1("in_ready_after_take", u_in_ready, 1'b1);
        chk1("out_valid_after_take", u_out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", u_in_ready, 1'b1);
        chk1("rst_out_valid", u_out_valid, 1'b0);
        chk8("rst_q", u_q, 8'h00);
        chk8("rst_r", s_r, 8'h00);
`ifdef V2F_DIVMOD_DBZ_EN
        chk1("rst_dbz", s_dbz, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk1("in_ready_after_rst", s_in_ready, 1'b1);

        // 100 / 7
        run_op(8'd100, 8'd7, lat);
        chk8("u_100_7_q", u_q, 8'd14);
        chk8("u_100_7_r", u_r, 8'd2);
        chk8("s_100_7_q", s_q, 8'd14);
        chk8("s_100_7_r", s_r, 8'd2);
`ifdef V2F_DIVMOD_DBZ_EN
        chk1("dbz_low_100_7", u_dbz, 1'b0);
`endif
        take_result();

        // -7 / 2 (unsigned view: 249 / 2)
        run_op(8'hF9, 8'h02, lat);
        chk8("s_m7_2_q", s_q, 8'hFD);
        chk8("s_m7_2_r", s_r, 8'hFF);
        chk8("u_249_2_q", u_q, 8'h7C);
        chk8("u_249_2_r", u_r, 8'h01);
        take_result();

        // 7 / -2 (unsigned view: 7 / 254)
        run_op(8'h07, 8'hFE, lat);
        chk8("s_7_m2_q", s_q, 8'hFD);
        chk8("s_7_m2_r", s_r, 8'h01);
        chk8("u_7_254_q", u_q, 8'h00);
        chk8("u_7_254_r", u_r, 8'h07);
        take_result();

        // Divide by zero
        run_op(8'd13, 8'd0, lat);
        chk8("u_dbz_q", u_q, 8'hFF);
        chk8("u_dbz_r", u_r, 8'd13);
        chk8("s_dbz_q", s_q, 8'hFF);
        chk8("s_dbz_r", s_r, 8'd13);
`ifdef V2F_DIVMOD_DBZ_EN
        chk1("u_dbz_flag", u_dbz, 1'b1);
        chk1("s_dbz_flag", s_dbz, 1'b1);
`endif
        take_result();

        // Divide by zero with a negative dividend: R is the raw dividend
        run_op(8'hF3, 8'd0, lat);
        chk8("s_dbz_neg_q", s_q, 8'hFF);
        chk8("s_dbz_neg_r", s_r, 8'hF3);
        take_result();

        // Signed overflow: -128 / -1 (unsigned view: 128 / 255)
        run_op(8'h80, 8'hFF, lat);
        chk8("s_ovf_q", s_q, 8'h80);
        chk8("s_ovf_r", s_r, 8'h00);
        chk8("u_128_255_q", u_q, 8'h00);
        chk8("u_128_255_r", u_r, 8'h80);
        take_result();

        // Backpressure: 200 / 9 (signed view: -56 / 9 = -6 rem -2)
        out_ready = 1'b0;
        run_op(8'd200, 8'd9, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 8'(i * 37 + 1); B = 8'(i + 3); in_valid = ~in_valid;
            @(posedge clk);
            #1;
            chk1("bp_out_valid", u_out_valid, 1'b1);
            chk1("bp_in_ready", u_in_ready, 1'b0);
            chk8("bp_u_q", u_q, 8'd22);
            chk8("bp_u_r", u_r, 8'd2);
            chk8("bp_s_q", s_q, 8'hFA);
            chk8("bp_s_r", s_r, 8'hFE);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        take_result();
        @(posedge clk);
        #1;
        chk1("bp_no_second_accept", u_in_ready, 1'b1);

        // Reset three cycles into RUN
        @(negedge clk);
        A = 8'd123; B = 8'd4; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("mid_rst_out_valid", u_out_valid, 1'b0);
        chk8("mid_rst_q", u_q, 8'h00);
        chk8("mid_rst_r", s_r, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("mid_rst_in_ready", u_in_ready, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk1("no_partial_result", u_out_valid, 1'b0);

        // New operation after reset: 50 / 5
        run_op(8'd50, 8'd5, lat);
        chk8("u_50_5_q", u_q, 8'd10);
        chk8("u_50_5_r", u_r, 8'd0);
        chk8("s_50_5_q", s_q, 8'd10);
        chk8("s_50_5_r", s_r, 8'd0);
        take_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
